ushift_4_arb: RTL and testbench

Two-requester arbiter and sequencer for the 4-bit universal register (`ushift_4`).
- Accepts register operations (hold, complement, clear, load) from two independent requesters.
- Grants one requester at a time, round-robin.
- Drives the register's `sel`/`i_par` inputs for a programmable number of cycles, then returns the register to hold.
- Sits directly in front of the register; its `sel` and `i_par` outputs wire straight to the register's `sel` and `i_par` inputs.

---
 rtl/ushift_4_arb.sv | 152 +++++++++++++++
 tb/tb_ushift_4_arb.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ushift_4_arb.sv
// ushift_4_arb: two-requester arbiter and sequencer for the 4-bit universal register.
//
// Grants one requester at a time and drives the register's sel/i_par for a
// per-command number of cycles. After that it returns the register to hold (sel = 00).
// Arbitration is round-robin by default. Define USHIFT_ARB_FIXED_PRI_EN to give
// requester 0 fixed priority.
//
// Ports:
//   clk            rising-edge clock (shared with the register)
//   clear_b        asynchronous active-low reset
//   req0/req1      requests
//   op0/op1        operation: 00 hold, 01 complement, 10 clear, 11 load
//   data0/data1    load value (used only for op 11)
//   len0/len1      cycles to apply the op (0 is treated as 1)
//   gnt0/gnt1      one-cycle grant pulse
//   sel/i_par      to the register's sel/i_par inputs
//   busy           high while a command is executing
//   done           one-cycle pulse after the last applied cycle
module ushift_4_arb #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned LEN_W = 3
) (
  input  logic             clk,
  input  logic             clear_b,
  input  logic             req0,
  input  logic             req1,
  input  logic [1:0]       op0,
  input  logic [1:0]       op1,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  input  logic [LEN_W-1:0] len0,
  input  logic [LEN_W-1:0] len1,
  output logic             gnt0,
  output logic             gnt1,
  output logic [1:0]       sel,
  output logic [WIDTH-1:0] i_par,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             last_q, last_d;
  logic             gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic [1:0]       sel_q, sel_d;
  logic [WIDTH-1:0] i_par_q, i_par_d;
  logic             busy_q, busy_d, done_q, done_d;

  logic             win1;
  logic [1:0]       win_op;
  logic [WIDTH-1:0] win_data;
  logic [LEN_W-1:0] win_len;

  // Winner selection; only meaningful when at least one request is high.
  always_comb begin
    if (req0 && req1) begin
`ifdef USHIFT_ARB_FIXED_PRI_EN
      win1 = 1'b0;
`else
      win1 = ~last_q;  // grant the requester that did not win last time
`endif
    end else begin
      win1 = req1;
    end
    win_op   = win1 ? op1 : op0;
    win_data = win1 ? data1 : data0;
    win_len  = win1 ? len1 : len0;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    sel_d   = sel_q;
    i_par_d = i_par_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req0 || req1) begin
          gnt0_d  = ~win1;
          gnt1_d  = win1;
          sel_d   = win_op;
          i_par_d = (win_op == 2'b11) ? win_data : '0;
          cnt_d   = (win_len == '0) ? LEN_W'(1) : win_len;
          busy_d  = 1'b1;
          last_d  = win1;
          state_d = StRun;
        end
      end
      StRun: begin
        // Count == 1 here means this edge is the last one that applies the op.
        if (cnt_q <= LEN_W'(1)) begin
          sel_d   = 2'b00;
          i_par_d = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - LEN_W'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        sel_d   = 2'b00;
        i_par_d = '0;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clear_b) begin
    if (!clear_b) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      sel_q   <= 2'b00;
      i_par_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      sel_q   <= sel_d;
      i_par_q <= i_par_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign gnt0  = gnt0_q;
  assign gnt1  = gnt1_q;
  assign sel   = sel_q;
  assign i_par = i_par_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_ushift_4_arb.sv
// Directed testbench for ushift_4_arb. A small register model follows sel/i_par
// so that register outcomes can be checked against hand-computed values.
// It honours USHIFT_ARB_FIXED_PRI_EN when that macro is defined.
module tb_ushift_4_arb;

  logic       clk;
  logic       clear_b;
  logic       req0, req1;
  logic [1:0] op0, op1;
  logic [3:0] data0, data1;
  logic [2:0] len0, len1;
  logic       gnt0, gnt1;
  logic [1:0] sel;
  logic [3:0] i_par;
  logic       busy, done;

  int checks;
  int errors;

  logic [3:0] reg_q;  // model of the attached ushift_4 register

  ushift_4_arb #(
    .WIDTH (4),
    .LEN_W (3)
  ) dut (
    .clk     (clk),
    .clear_b (clear_b),
    .req0    (req0),
    .req1    (req1),
    .op0     (op0),
    .op1     (op1),
    .data0   (data0),
    .data1   (data1),
    .len0    (len0),
    .len1    (len1),
    .gnt0    (gnt0),
    .gnt1    (gnt1),
    .sel     (sel),
    .i_par   (i_par),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk or negedge clear_b) begin
    if (!clear_b) reg_q <= 4'b0000;
    else begin
      case (sel)
        2'b01:   reg_q <= ~reg_q;
        2'b10:   reg_q <= 4'b0000;
        2'b11:   reg_q <= i_par;
        default: reg_q <= reg_q;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_b = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    op0 = 2'b00; op1 = 2'b00;
    data0 = 4'h0; data1 = 4'h0;
    len0 = 3'd0; len1 = 3'd0;
    #23;
    checks++;
    if ({gnt0, gnt1, sel, i_par, busy, done} !== 10'b0) begin
      errors++;
      $display("FAIL reset_outputs: got gnt0=%b gnt1=%b sel=%b i_par=%b busy=%b done=%b, want all 0",
               gnt0, gnt1, sel, i_par, busy, done);
    end
    clear_b = 1'b1;
    tick();
    checks++;
    if ({gnt0, gnt1, busy} !== 3'b000) begin
      errors++;
      $display("FAIL reset_idle: got gnt0=%b gnt1=%b busy=%b, want 000", gnt0, gnt1, busy);
    end
  endtask

  // Both requesters held high, op hold len 1: a grant every 3 cycles.
  task automatic test_contention();
    logic exp0, exp1;
    req0 = 1'b1; req1 = 1'b1;
    op0 = 2'b00; op1 = 2'b00;
    len0 = 3'd1; len1 = 3'd1;
    for (int i = 0; i < 12; i++) begin
      tick();
      exp0 = 1'b0;
      exp1 = 1'b0;
      if (i % 3 == 0) begin
`ifdef USHIFT_ARB_FIXED_PRI_EN
        exp0 = 1'b1;
`else
        if ((i / 3) % 2 == 0) exp0 = 1'b1;
        else exp1 = 1'b1;
`endif
      end
      checks++;
      if (gnt0 !== exp0 || gnt1 !== exp1) begin
        errors++;
        $display("FAIL contention_cycle%0d: got gnt0=%b gnt1=%b, want gnt0=%b gnt1=%b",
                 i, gnt0, gnt1, exp0, exp1);
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();
    checks++;
    if ({gnt0, gnt1, busy} !== 3'b000) begin
      errors++;
      $display("FAIL contention_release: got gnt0=%b gnt1=%b busy=%b, want 000", gnt0, gnt1, busy);
    end
  endtask

  task automatic test_single_load();
    req0 = 1'b1; op0 = 2'b11; data0 = 4'b1011; len0 = 3'd1;
    tick();
    req0 = 1'b0;
    checks++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || sel !== 2'b11 || i_par !== 4'b1011 ||
        busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL load_grant: got gnt0=%b gnt1=%b sel=%b i_par=%b busy=%b done=%b, want 1 0 11 1011 1 0",
               gnt0, gnt1, sel, i_par, busy, done);
    end
    tick();
    checks++;
    if (gnt0 !== 1'b0 || sel !== 2'b00 || i_par !== 4'b0000 || busy !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("FAIL load_done: got gnt0=%b sel=%b i_par=%b busy=%b done=%b, want 0 00 0000 0 1",
               gnt0, sel, i_par, busy, done);
    end
    checks++;
    if (reg_q !== 4'b1011) begin
      errors++;
      $display("FAIL load_reg: got %b want 1011", reg_q);
    end
    tick();
    checks++;
    if (done !== 1'b0 || sel !== 2'b00) begin
      errors++;
      $display("FAIL load_after: got done=%b sel=%b, want 0 00", done, sel);
    end
  endtask

  task automatic test_complement();
    int busy_cycles;
    busy_cycles = 0;
    req1 = 1'b1; op1 = 2'b01; data1 = 4'b1111; len1 = 3'd3;
    tick();
    req1 = 1'b0;
    checks++;
    if (gnt1 !== 1'b1 || gnt0 !== 1'b0 || sel !== 2'b01 || i_par !== 4'b0000) begin
      errors++;
      $display("FAIL comp_grant: got gnt1=%b gnt0=%b sel=%b i_par=%b, want 1 0 01 0000",
               gnt1, gnt0, sel, i_par);
    end
    for (int i = 0; i < 5; i++) begin
      if (busy === 1'b1) busy_cycles++;
      if (i < 2) begin
        tick();
        checks++;
        if (sel !== 2'b01 || gnt1 !== 1'b0) begin
          errors++;
          $display("FAIL comp_run%0d: got sel=%b gnt1=%b, want 01 0", i, sel, gnt1);
        end
      end else begin
        tick();
      end
    end
    checks++;
    if (busy_cycles != 3) begin
      errors++;
      $display("FAIL comp_busy_len: got %0d busy cycles, want 3", busy_cycles);
    end
    checks++;
    if (reg_q !== 4'b0100) begin
      errors++;
      $display("FAIL comp_reg: got %b want 0100", reg_q);
    end
  endtask

  task automatic test_len_zero();
    req0 = 1'b1; op0 = 2'b10; data0 = 4'b1111; len0 = 3'd0;
    tick();
    req0 = 1'b0;
    checks++;
    if (gnt0 !== 1'b1 || sel !== 2'b10 || i_par !== 4'b0000) begin
      errors++;
      $display("FAIL len0_grant: got gnt0=%b sel=%b i_par=%b, want 1 10 0000", gnt0, sel, i_par);
    end
    tick();
    checks++;
    if (sel !== 2'b00 || done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL len0_done: got sel=%b done=%b busy=%b, want 00 1 0", sel, done, busy);
    end
    checks++;
    if (reg_q !== 4'b0000) begin
      errors++;
      $display("FAIL len0_reg: got %b want 0000", reg_q);
    end
    tick();
  endtask

  // req1 arrives during a len 4 command from requester 0 and must wait until IDLE.
  task automatic test_ignore_busy();
    req0 = 1'b1; op0 = 2'b00; len0 = 3'd4;
    tick();
    req0 = 1'b0;
    checks++;
    if (gnt0 !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_grant0: got gnt0=%b busy=%b, want 1 1", gnt0, busy);
    end
    req1 = 1'b1; op1 = 2'b01; len1 = 3'd1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      checks++;
      if (gnt1 !== 1'b0 || done !== (i == 4)) begin
        errors++;
        $display("FAIL busy_wait%0d: got gnt1=%b done=%b, want 0 %b", i, gnt1, done, (i == 4));
      end
    end
    tick();
    req1 = 1'b0;
    checks++;
    if (gnt1 !== 1'b1 || sel !== 2'b01) begin
      errors++;
      $display("FAIL busy_grant1: got gnt1=%b sel=%b, want 1 01", gnt1, sel);
    end
    tick();
    tick();
  endtask

  task automatic test_reset_mid_run();
    req0 = 1'b1; op0 = 2'b11; data0 = 4'b1010; len0 = 3'd5;
    tick();
    req0 = 1'b0;
    tick();
    tick();
    clear_b = 1'b0;
    #1;
    checks++;
    if (sel !== 2'b00 || i_par !== 4'b0000 || busy !== 1'b0 || gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
      errors++;
      $display("FAIL midrun_reset: got sel=%b i_par=%b busy=%b gnt0=%b gnt1=%b, want 00 0000 0 0 0",
               sel, i_par, busy, gnt0, gnt1);
    end
    #1;
    clear_b = 1'b1;
    req0 = 1'b1; req1 = 1'b1;
    op0 = 2'b11; data0 = 4'b0110; len0 = 3'd2;
    op1 = 2'b10; len1 = 3'd1;
    tick();
    req0 = 1'b0; req1 = 1'b0;
    checks++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || sel !== 2'b11) begin
      errors++;
      $display("FAIL midrun_tie: got gnt0=%b gnt1=%b sel=%b, want 1 0 11", gnt0, gnt1, sel);
    end
    tick();
    tick();
    checks++;
    if (done !== 1'b1 || reg_q !== 4'b0110) begin
      errors++;
      $display("FAIL midrun_after: got done=%b reg=%b, want 1 0110", done, reg_q);
    end
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_contention();
    test_single_load();
    test_complement();
    test_len_zero();
    test_ignore_busy();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
